// File: rtl/seg_digit_scanner.sv
// Four-digit multiplexed BCD display scanner with a frame-synchronous double-buffered digit register.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit0 always lit).
module seg_digit_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        enable,
  output logic [3:0]  bcd_out,
  output logic [1:0]  digit_sel,
  output logic [3:0]  an,
  output logic        tick,
  output logic        err
);

  localparam logic [DIV_W-1:0] TC = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [3:0]       bcd_q, bcd_d;
  logic [3:0]       an_q, an_d;
  logic             adv_s;
  logic             frame_s;
  logic [3:0]       blank_s;

  function automatic logic has_non_bcd(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [15:0] v, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Leading-zero mask: a digit is blanked only if it and every digit above it is zero.
  function automatic logic [3:0] lead_blank(input logic [15:0] v);
    logic [3:0] m;
    m    = 4'b0000;
    m[3] = (v[15:12] == 4'h0);
    m[2] = m[3] && (v[11:8] == 4'h0);
    m[1] = m[2] && (v[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

  // Next-state logic for prescaler, digit index, buffers and registered outputs.
  always_comb begin
    presc_d  = presc_q;
    sel_d    = sel_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    err_d    = err_q;
    bcd_d    = bcd_q;
    an_d     = an_q;
    blank_s  = 4'b0000;

    adv_s   = enable && (presc_q == TC);
    frame_s = adv_s && (sel_q == 2'd3);

    if (enable) begin
      presc_d = adv_s ? '0 : (presc_q + DIV_W'(1));
    end else begin
      presc_d = presc_q;
    end

    if (adv_s) begin
      sel_d  = sel_q + 2'd1;
      tick_d = 1'b1;
    end else begin
      sel_d  = sel_q;
      tick_d = 1'b0;
    end

    // New digits only take effect on a frame boundary so a frame is never mixed.
    if (frame_s) begin
      if (load) begin
        disp_d   = digits_in;
        shadow_d = digits_in;
      end else if (pend_q) begin
        disp_d = shadow_q;
      end else begin
        disp_d = disp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      shadow_d = digits_in;
      pend_d   = 1'b1;
    end else begin
      shadow_d = shadow_q;
      pend_d   = pend_q;
    end

    if (load) begin
      err_d = err_q | has_non_bcd(digits_in);
    end else begin
      err_d = err_q;
    end

`ifdef LEAD_ZERO_BLANK_EN
    blank_s = lead_blank(disp_d);
`else
    blank_s = 4'b0000;
`endif

    bcd_d = nibble_at(disp_d, sel_d);
    if (enable) begin
      an_d = ~(4'b0001 << sel_d) | blank_s;
    end else begin
      an_d = 4'b1111;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      sel_q    <= 2'd0;
      disp_q   <= 16'h0000;
      shadow_q <= 16'h0000;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      bcd_q    <= 4'h0;
      an_q     <= 4'b1111;
    end else begin
      presc_q  <= presc_d;
      sel_q    <= sel_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      bcd_q    <= bcd_d;
      an_q     <= an_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign digit_sel = sel_q;
  assign an        = an_q;
  assign tick      = tick_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Randomized plus directed bench for seg_digit_scanner (REFRESH_DIV=4) against a behavioural model.
module tb_seg_digit_scanner;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        enable = 1'b0;
  logic [3:0]  bcd_out;
  logic [1:0]  digit_sel;
  logic [3:0]  an;
  logic        tick;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_presc, m_sel;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend, m_err, m_tick;
  logic [3:0]  m_bcd, m_an;

  seg_digit_scanner #(.REFRESH_DIV(DIV), .DIV_W(3)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .enable(enable),
    .bcd_out(bcd_out), .digit_sel(digit_sel), .an(an), .tick(tick), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int i);
    return 4'((v >> (4 * i)) & 16'h000F);
  endfunction

  function automatic logic [3:0] model_blank(input logic [15:0] v);
    logic [3:0] m;
    m = 4'b0000;
`ifdef LEAD_ZERO_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (nib(v, i) != 4'h0) break;
      m[i] = 1'b1;
    end
`endif
    return m;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_sel = 0; m_disp = 16'h0; m_shadow = 16'h0;
    m_pend = 0; m_err = 0; m_tick = 0; m_bcd = 4'h0; m_an = 4'hF;
  endtask

  task automatic model_step(input bit en, input bit ld, input logic [15:0] din);
    bit adv, boundary;
    adv      = en && (m_presc == DIV - 1);
    boundary = adv && (m_sel == 3);
    if (en) m_presc = adv ? 0 : m_presc + 1;
    if (ld) for (int i = 0; i < 4; i++) if (nib(din, i) > 4'd9) m_err = 1;
    if (boundary) begin
      if (ld) m_disp = din;
      else if (m_pend) m_disp = m_shadow;
      m_pend = 0;
    end else if (ld) begin
      m_shadow = din;
      m_pend   = 1;
    end
    if (adv) m_sel = (m_sel + 1) % 4;
    m_tick = adv;
    m_bcd  = nib(m_disp, m_sel);
    m_an   = en ? ((~(4'b0001 << m_sel)) | model_blank(m_disp)) : 4'b1111;
  endtask

  // Called just after a falling edge: drive, clock, then compare at the next falling edge.
  task automatic run_cycle(input bit en, input bit ld, input logic [15:0] din);
    enable = en; load = ld; digits_in = din;
    @(posedge clk);
    model_step(en, ld, din);
    @(negedge clk);
    load = 1'b0;
    check_eq("bcd_out", 16'(bcd_out), 16'(m_bcd));
    check_eq("digit_sel", 16'(digit_sel), 16'(m_sel));
    check_eq("an", 16'(an), 16'(m_an));
    check_eq("tick", 16'(tick), 16'(m_tick));
    check_eq("err", 16'(err), 16'(m_err));
  endtask

  // Reset asserted between clock edges; outputs must change without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_an", 16'(an), 16'hF);
    check_eq("rst_bcd", 16'(bcd_out), 16'h0);
    check_eq("rst_sel", 16'(digit_sel), 16'h0);
    check_eq("rst_err", 16'(err), 16'h0);
    check_eq("rst_tick", 16'(tick), 16'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 19) == 0) v[i*4 +: 4] = 4'($urandom_range(0, 15));
      else v[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    bit found;
    model_reset();
    @(negedge clk);
    async_reset();

    // Load 1234 and step through one full frame after the boundary.
    run_cycle(1'b1, 1'b1, 16'h1234);
    for (int i = 0; i < 15; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("f1_bcd0", 16'(bcd_out), 16'h4);
    check_eq("f1_an0", 16'(an), 16'hE);
    check_eq("f1_tick", 16'(tick), 16'h1);
    run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("f1_tick_low", 16'(tick), 16'h0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("f1_bcd1", 16'(bcd_out), 16'h3);
    check_eq("f1_an1", 16'(an), 16'hD);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("f1_bcd2", 16'(bcd_out), 16'h2);
    check_eq("f1_an2", 16'(an), 16'hB);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("f1_bcd3", 16'(bcd_out), 16'h1);
    check_eq("f1_an3", 16'(an), 16'h7);

    // Mid-frame load must not disturb digits 2 and 3 of the current frame.
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("mid_sel1", 16'(digit_sel), 16'h1);
    run_cycle(1'b1, 1'b1, 16'h5678);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("mid_old2", 16'(bcd_out), 16'h2);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("mid_old3", 16'(bcd_out), 16'h1);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("mid_new0", 16'(bcd_out), 16'h8);

    // Disable scanning at digit 2 and check it holds, blanked, then resumes.
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("dis_sel_before", 16'(digit_sel), 16'h2);
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 1'b0, 16'h0);
      check_eq("dis_an", 16'(an), 16'hF);
      check_eq("dis_sel", 16'(digit_sel), 16'h2);
      check_eq("dis_tick", 16'(tick), 16'h0);
    end
    run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("reen_sel", 16'(digit_sel), 16'h2);
    check_eq("reen_an", 16'(an), 16'hB);

    // Non-BCD nibble sets sticky err and is displayed unmodified.
    run_cycle(1'b1, 1'b1, 16'h12A4);
    check_eq("err_set", 16'(err), 16'h1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_cycle(1'b1, 1'b0, 16'h0);
      if (m_sel == 1 && m_disp == 16'h12A4) begin
        check_eq("bcd_A", 16'(bcd_out), 16'hA);
        found = 1;
      end
    end
    check_eq("found_A", 16'(found), 16'h1);
    check_eq("err_sticky", 16'(err), 16'h1);

    // Pending load is lost across reset.
    run_cycle(1'b1, 1'b1, 16'h9999);
    async_reset();
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b0, 16'h0);
    check_eq("lost_pend", 16'(bcd_out), 16'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else run_cycle($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, rand_digits());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_digit_scanner.md
SEG_DIGIT_SCANNER -- requirements
Module: seg_digit_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles each digit stays selected; legal range 2 to 2^20.
REQ-003 Parameter DIV_W, default 20: prescaler counter width; 2^DIV_W SHALL be at least REFRESH_DIV.
REQ-004 clk  in  1  system clock, rising-edge active.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 load  in  1  one-cycle strobe that captures digits_in.
REQ-007 digits_in  in  16  four BCD nibbles; [3:0] is digit0 (rightmost) and [15:12] is digit3.
REQ-008 enable  in  1  scan enable; low blanks the display.
REQ-009 bcd_out  out  4  BCD nibble of the selected digit; feeds the BCD-to-7-segment decoder.
REQ-010 digit_sel  out  2  index of the selected digit.
REQ-011 an  out  4  active-low one-hot anode enables; an[i] drives digit i.
REQ-012 tick  out  1  one-cycle pulse on each digit advance.
REQ-013 err  out  1  sticky flag for a non-BCD nibble.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 while enable=1 and wrap to 0; its terminal count is the advance event.
REQ-015 On an advance, digit_sel SHALL increment modulo 4 (3->0 is the frame boundary) and tick SHALL be 1 for exactly the following cycle.
REQ-016 digit_sel, bcd_out and an SHALL all be registered and SHALL update on the same clk edge; there is no intermediate state.
REQ-017 bcd_out SHALL equal the display-register nibble indexed by digit_sel, passed through unmodified even when the value is greater than 9.
REQ-018 While enable=1, an SHALL be ~(1<<digit_sel); while enable=0, an SHALL be 4'b1111 from the next edge.
REQ-019 While enable=0, the prescaler and digit_sel SHALL hold and tick SHALL be 0; after re-enable, scanning SHALL resume from the held values.
REQ-020 load=1 SHALL write digits_in into a shadow register and set pending; a second load before the frame boundary SHALL overwrite the shadow register.
REQ-021 At the frame boundary with pending=1, the shadow register SHALL copy into the display register and pending SHALL clear, so a frame never mixes old and new digits.
REQ-022 load coinciding with the frame boundary SHALL copy digits_in directly into the display register and leave pending=0.
REQ-023 Any loaded nibble greater than 9 SHALL set err on the next edge; err SHALL stay 1 until reset.
REQ-024 load while enable=0 SHALL still capture data; the transfer waits for the next frame boundary after scanning resumes.

Reset
REQ-025 rst=1 SHALL act immediately without a clock, setting:
- prescaler, digit_sel, the display register and the shadow register to 0;
- pending, tick and err to 0;
- bcd_out to 4'h0 and an to 4'b1111.
REQ-026 After rst is released, the first clk edge with enable=1 SHALL drive an=4'b1110; reset mid-scan SHALL discard pending data.

Configuration
REQ-027 With macro LEAD_ZERO_BLANK_EN defined, an[i] SHALL be forced to 1 for each leading zero digit (counted from digit3 downward, stopping at the first nonzero digit); digit0 is never blanked, and digit_sel timing is unchanged.
REQ-028 Without LEAD_ZERO_BLANK_EN, all four digits SHALL light per REQ-018 regardless of value.

Verification (REFRESH_DIV=4)
REQ-029 Reset, enable=1, load 16'h1234 and wait for one frame boundary -> bcd_out 4,3,2,1 for 4 cycles each; an 1110,1101,1011,0111; tick pulses every 4 cycles.
REQ-030 Display 16'h1234, then load 16'h5678 while digit_sel=1 -> digits 2 and 3 still show 2,1; 8,7,6,5 appear from digit_sel=0.
REQ-031 Drop enable at digit_sel=2 for 10 cycles -> an=1111 and digit_sel stays 2 with tick=0; after re-enable, scanning resumes at 2.
REQ-032 Load 16'h12A4 -> err=1 next cycle and stays set; bcd_out=4'hA while digit_sel=1; err clears only on rst.
REQ-033 With LEAD_ZERO_BLANK_EN defined, load 16'h0047 -> an[3] and an[2] stay 1; 16'h0000 -> only an[0] is ever active.
REQ-034 Assert rst between clk edges mid-scan -> an=1111, bcd_out=0, digit_sel=0, err=0 immediately; pending load is lost.
